// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the divided-clock period monitor.
package clkdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQUIRE = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_STALL   = 3'd4
  } state_t;

  // Debug view of the monitor: FSM state plus the synchronised input and its edges.
  typedef struct packed {
    state_t state;
    logic   sync;
    logic   rise;
    logic   fall;
  } dbg_t;

  localparam int         CNT_W_DEF      = 8;
  localparam int         LOCK_COUNT_DEF = 3;
  localparam int         TIMEOUT_DEF    = 255;
  localparam logic [3:0] RATIO_MIN      = 4'd2;

endpackage

// File: rtl/clkdiv_period_monitor_if.sv
// Signal bundle between the divider side (master) and the period monitor (slave).
// meas_valid is a one-cycle pulse with no ready: the consumer must sample it that cycle.
interface clkdiv_period_monitor_if
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             div_in;
  logic [3:0]       exp_ratio;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             period_ok;
  logic             duty_ok;
  logic             locked;
  logic [CNT_W-1:0] err_count;
  logic             stalled;

  modport master (
    output div_in, exp_ratio,
    input  period, high_time, meas_valid, period_ok, duty_ok, locked, err_count, stalled
  );

  modport slave (
    input  div_in, exp_ratio,
    output period, high_time, meas_valid, period_ok, duty_ok, locked, err_count, stalled
  );
endinterface

// File: rtl/clkdiv_edge_sync.sv
// Two-flop synchroniser for the divided clock followed by an edge-detect flop.
module clkdiv_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;
endmodule

// File: rtl/clkdiv_period_monitor.sv
// Measures period and high time of a divided clock in source-clock cycles and
// reports lock, mismatch count and stall against the expected division ratio.
module clkdiv_period_monitor
  import clkdiv_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  clkdiv_period_monitor_if.slave  bus,
  output dbg_t                    dbg
);
  localparam int               GR_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [GR_W-1:0]  LOCK_C    = GR_W'(LOCK_COUNT);

  logic             sync;
  logic             rise;
  logic             fall;
  state_t           state;
  logic [3:0]       ratio_q;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [GR_W-1:0]  good_run;

  clkdiv_edge_sync u_sync (
    .clk   (clk),
    .rst_n (reset),
    .din   (bus.div_in),
    .sync  (sync),
    .rise  (rise),
    .fall  (fall)
  );

  logic             ratio_chg;
  logic [CNT_W-1:0] exp_ext;
  logic             per_good;
  logic             hi_good;
  logic [GR_W-1:0]  good_next;

  assign ratio_chg = (bus.exp_ratio != ratio_q);
  assign exp_ext   = CNT_W'(bus.exp_ratio);
  // A saturated cyc_cnt can never equal a 4-bit ratio, so it always counts as bad.
  assign per_good  = (cyc_cnt == exp_ext);
  assign hi_good   = (hi_cnt == (exp_ext >> 1)) || (hi_cnt == ((exp_ext + CNT_W'(1)) >> 1));
  assign good_next = (good_run == LOCK_C) ? LOCK_C : good_run + GR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      ratio_q        <= '0;
      cyc_cnt        <= '0;
      hi_cnt         <= '0;
      good_run       <= '0;
      bus.period     <= '0;
      bus.high_time  <= '0;
      bus.meas_valid <= 1'b0;
      bus.period_ok  <= 1'b0;
      bus.duty_ok    <= 1'b0;
      bus.locked     <= 1'b0;
      bus.err_count  <= '0;
      bus.stalled    <= 1'b0;
    end else begin
      bus.meas_valid <= 1'b0;
      ratio_q        <= bus.exp_ratio;
      if (ratio_chg) begin
        // A new ratio wins over any rise or timeout: restart acquisition from scratch.
        cyc_cnt       <= '0;
        hi_cnt        <= '0;
        good_run      <= '0;
        bus.locked    <= 1'b0;
        bus.err_count <= '0;
        bus.stalled   <= 1'b0;
        state         <= (bus.exp_ratio < RATIO_MIN) ? ST_IDLE : ST_ACQUIRE;
      end else if (state == ST_IDLE) begin
        cyc_cnt    <= '0;
        hi_cnt     <= '0;
        bus.locked <= 1'b0;
        if (bus.exp_ratio >= RATIO_MIN) state <= ST_ACQUIRE;
      end else begin
        if (rise) begin
          cyc_cnt <= CNT_W'(1);
          hi_cnt  <= CNT_W'(1);
        end else begin
          if (cyc_cnt != CNT_MAX) cyc_cnt <= cyc_cnt + CNT_W'(1);
          if (sync && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CNT_W'(1);
        end

        if (rise) begin
          case (state)
            ST_ACQUIRE, ST_STALL: begin
              bus.stalled <= 1'b0;
              state       <= ST_MEASURE;
            end
            default: begin
              bus.period     <= cyc_cnt;
              bus.high_time  <= hi_cnt;
              bus.meas_valid <= 1'b1;
              bus.period_ok  <= per_good;
              bus.duty_ok    <= hi_good;
              if (per_good && hi_good) begin
                good_run <= good_next;
                if (good_next == LOCK_C) begin
                  state      <= ST_LOCKED;
                  bus.locked <= 1'b1;
                end
              end else begin
                good_run   <= '0;
                bus.locked <= 1'b0;
                state      <= ST_MEASURE;
                if (bus.err_count != CNT_MAX) bus.err_count <= bus.err_count + CNT_W'(1);
              end
            end
          endcase
        end else if (cyc_cnt == TIMEOUT_C) begin
          state       <= ST_STALL;
          bus.stalled <= 1'b1;
          bus.locked  <= 1'b0;
          good_run    <= '0;
        end
      end
    end
  end

  assign dbg.state = state;
  assign dbg.sync  = sync;
  assign dbg.rise  = rise;
  assign dbg.fall  = fall;
endmodule

// File: tb/tb_clkdiv_period_monitor.sv
// Bench for clkdiv_period_monitor: a behavioural divider drives div_in, a timestamp
// model predicts every output each cycle, and directed scenarios pin key values.
module tb_clkdiv_period_monitor;
  import clkdiv_pkg::*;

  localparam int CNT_W  = 8;
  localparam int LOCK_N = 3;
  localparam int TMO    = 255;
  localparam int CMAX   = 255;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clkdiv_period_monitor_if #(.CNT_W(CNT_W)) bus ();
  dbg_t dbg;

  clkdiv_period_monitor #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK_N), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus),
    .dbg   (dbg)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({bus.period, bus.high_time, bus.meas_valid, bus.period_ok,
                bus.duty_ok, bus.locked, bus.err_count, bus.stalled});
  endfunction

  // ---------------- divider model (stimulus) ----------------
  int g_n = 6, g_n_next = 6, g_hi = 3, g_ph = 0;
  bit g_en = 1'b0, g_rand_hi = 1'b0;

  task automatic gen_next(output logic v);
    if (!g_en) begin
      g_ph = 0;
      v    = 1'b0;
    end else begin
      if (g_ph == 0) begin
        g_n = g_n_next;
        if (g_rand_hi && $urandom_range(9) == 0) g_hi = $urandom_range(g_n - 1, 1);
        else g_hi = ($urandom_range(1) == 1) ? g_n / 2 : (g_n + 1) / 2;
      end
      v    = (g_ph < g_hi);
      g_ph = (g_ph + 1) % g_n;
    end
  endtask

  // ---------------- reference model ----------------
  // The current period starts at edge m_b; m_h counts synchronised-high edges since then.
  int  kcyc = 0;
  int  m_b = 1, m_h = 0, m_eprev = 0;
  bit  d1, d2, d3;
  int  m_mode = 0;  // 0 idle, 1 acquiring, 2 measuring, 3 stalled
  int  m_good = 0, m_err = 0, m_per = 0, m_ht = 0;
  bit  m_mv, m_pok, m_dok, m_lock, m_stall;

  function automatic logic [31:0] model_vec();
    return 32'({8'(m_per), 8'(m_ht), m_mv, m_pok, m_dok, m_lock, 8'(m_err), m_stall});
  endfunction

  task automatic model_step(input bit r, input bit d, input int e);
    bit rise, sync, zero;
    int cyc, hi;
    if (!r) begin
      m_mode = 0; m_good = 0; m_err = 0; m_per = 0; m_ht = 0;
      m_mv = 0; m_pok = 0; m_dok = 0; m_lock = 0; m_stall = 0;
      m_eprev = 0; d1 = 0; d2 = 0; d3 = 0; m_h = 0; m_b = kcyc + 1;
    end else begin
      rise = d2 && !d3;
      sync = d2;
      cyc  = (kcyc - m_b > CMAX) ? CMAX : kcyc - m_b;
      hi   = (m_h > CMAX) ? CMAX : m_h;
      m_mv = 0;
      zero = 0;
      if (e != m_eprev) begin
        m_lock = 0; m_good = 0; m_err = 0; m_stall = 0;
        m_mode = (e < 2) ? 0 : 1;
        zero   = 1;
      end else if (m_mode == 0) begin
        zero = 1;
        if (e >= 2) m_mode = 1;
      end else if (rise) begin
        if (m_mode == 1 || m_mode == 3) begin
          m_stall = 0;
          m_mode  = 2;
        end else begin
          m_per = cyc; m_ht = hi; m_mv = 1;
          m_pok = (cyc == e);
          m_dok = (hi == e / 2) || (hi == (e + 1) / 2);
          if (m_pok && m_dok) begin
            if (m_good < LOCK_N) m_good++;
            if (m_good == LOCK_N) m_lock = 1;
          end else begin
            m_good = 0;
            m_lock = 0;
            if (m_err < CMAX) m_err++;
          end
        end
        m_b = kcyc;
        m_h = 0;
      end else if (cyc == TMO) begin
        m_stall = 1; m_lock = 0; m_good = 0; m_mode = 3;
      end
      if (zero) begin
        m_b = kcyc + 1;
        m_h = 0;
      end else begin
        m_h += int'(sync);
      end
      m_eprev = e;
      d3 = d2; d2 = d1; d1 = d;
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    logic v;
    @(negedge clk);
    gen_next(v);
    bus.div_in = v;
    @(posedge clk);
    #1;
    model_step(rst_n, bus.div_in, int'(bus.exp_ratio));
    kcyc++;
    chk("cycle_outputs", dut_vec(), model_vec());
  endtask

  task automatic wait_mv(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      got = bus.meas_valid;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic lock_at(input int n, input string name);
    bus.exp_ratio = 4'(n);
    g_n_next      = n;
    for (int i = 0; i < 3; i++) wait_mv(name);
    chk({name, "_locked"}, 32'(bus.locked), 32'd1);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int stall_at, mv_cnt;
    bus.div_in    = 1'b0;
    bus.exp_ratio = 4'd6;
    rst_n         = 1'b0;
    tick(); tick();
    chk("reset_outputs", dut_vec(), 32'd0);
    chk("reset_state", 32'(dbg.state), 32'(ST_IDLE));

    // N=6: first measured period 6 / high 3, lock on the third measurement
    rst_n = 1'b1; g_en = 1'b1; g_n_next = 6; g_ph = 0;
    wait_mv("n6_mv1");
    chk("n6_period", 32'(bus.period), 32'd6);
    chk("n6_high", 32'(bus.high_time), 32'd3);
    chk("n6_unlocked_1", 32'(bus.locked), 32'd0);
    wait_mv("n6_mv2");
    chk("n6_unlocked_2", 32'(bus.locked), 32'd0);
    wait_mv("n6_mv3");
    chk("n6_lock_3rd", 32'(bus.locked), 32'd1);
    chk("n6_err", 32'(bus.err_count), 32'd0);

    // N=5: odd ratio, either high time is acceptable
    bus.exp_ratio = 4'd5; g_n_next = 5;
    wait_mv("n5_mv1");
    chk("n5_period", 32'(bus.period), 32'd5);
    chk("n5_duty_ok", 32'(bus.duty_ok), 32'd1);
    chk("n5_unlocked", 32'(bus.locked), 32'd0);
    wait_mv("n5_mv2");
    wait_mv("n5_mv3");
    chk("n5_lock_3rd", 32'(bus.locked), 32'd1);

    // Wrong expected ratio while the divider stays at 6
    lock_at(6, "relock6a");
    bus.exp_ratio = 4'd7;
    tick();
    chk("chg_drop_lock", 32'(bus.locked), 32'd0);
    chk("chg_acquire", 32'(dbg.state), 32'(ST_ACQUIRE));
    for (int i = 0; i < 3; i++) begin
      wait_mv("bad_mv");
      chk("bad_period_ok", 32'(bus.period_ok), 32'd0);
    end
    chk("bad_err3", 32'(bus.err_count), 32'd3);
    chk("bad_nolock", 32'(bus.locked), 32'd0);

    // Stall: div_in held low right after a measured rise
    lock_at(6, "relock6b");
    g_en = 1'b0;
    stall_at = 0;
    for (int i = 1; i <= 400 && stall_at == 0; i++) begin
      tick();
      if (bus.stalled) stall_at = i;
    end
    chk("stall_delay", 32'(stall_at), 32'(TMO));
    chk("stall_unlocked", 32'(bus.locked), 32'd0);
    g_en = 1'b1;
    mv_cnt = 0;
    for (int i = 0; i < 20 && bus.stalled; i++) begin
      tick();
      mv_cnt += int'(bus.meas_valid);
    end
    chk("stall_cleared", 32'(bus.stalled), 32'd0);
    chk("stall_clear_no_mv", 32'(mv_cnt), 32'd0);
    for (int i = 0; i < 2; i++) begin
      wait_mv("post_stall_mv");
      chk("post_stall_unlocked", 32'(bus.locked), 32'd0);
    end
    wait_mv("post_stall_mv3");
    chk("post_stall_lock", 32'(bus.locked), 32'd1);

    // Monitor disabled
    bus.exp_ratio = 4'd1;
    mv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      mv_cnt += int'(bus.meas_valid);
    end
    chk("idle_no_mv", 32'(mv_cnt), 32'd0);
    chk("idle_state", 32'(dbg.state), 32'(ST_IDLE));
    lock_at(6, "idle_relock");

    // Reset mid-period while locked; release while div_in is low
    for (int i = 0; i < 20 && g_ph != g_hi; i++) tick();
    chk("pre_reset_locked", 32'(bus.locked), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", dut_vec(), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_mv("rst_mv");
      chk("rst_unlocked", 32'(bus.locked), 32'd0);
    end
    wait_mv("rst_mv3");
    chk("rst_relock", 32'(bus.locked), 32'd1);

    // Randomised segments checked cycle by cycle against the model
    g_rand_hi = 1'b1;
    for (int s = 0; s < 40; s++) begin
      int n, e, len;
      n = $urandom_range(15, 2);
      e = ($urandom_range(3) == 0) ? $urandom_range(15, 0) : n;
      g_n_next = n;
      bus.exp_ratio = 4'(e);
      if ($urandom_range(11) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      if ($urandom_range(7) == 0) begin
        g_en = 1'b0;
        len = $urandom_range(265, 250);
        for (int i = 0; i < len; i++) tick();
        g_en = 1'b1;
      end
      len = $urandom_range(150, 30);
      for (int i = 0; i < len; i++) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
